gpio_seq: RTL
=============

// Module: gpio_seq
// PURPOSE
//  Hardware pattern sequencer and port arbiter in front of the GPIO register port.
//  - Software loads a small program of timed GPIO write commands (OUT/SET/CLR/TGL plus delay).
//  - The sequencer replays the program cycle-accurately, once or looped.
//  - CPU GPIO accesses pass through and always win arbitration over sequencer writes.
// PARAMETERS
//  DEPTH  16  number of program entries (power of 2, 2..64)
//  DLY_W  16  width of per-entry delay field (cycles or ticks)
// PORTS
//  clk_i           in   1      clock
//  rst_i           in   1      synchronous reset, active-high
//  stb_i           in   1      config register access strobe
//  adr_i           in   3      config register word index
//  we_i            in   1      config write enable (full-word writes only)
//  dat_i           in   XLEN   config write data
//  dat_o           out  XLEN   config read data (combinational on adr_i)
//  cpu_stb_i       in   1      CPU access to GPIO
//  cpu_adr_i       in   4      CPU GPIO register index
//  cpu_byte_sel_i  in   4      CPU byte select
//  cpu_we_i        in   1      CPU write enable
//  cpu_dat_i       in   XLEN   CPU write data
//  m_stb_o         out  1      GPIO port strobe
//  m_adr_o         out  4      GPIO port register index
//  m_byte_sel_o    out  4      GPIO port byte select
//  m_we_o          out  1      GPIO port write enable
//  m_dat_o         out  XLEN   GPIO port write data
//  busy_o          out  1      sequencer running
//  done_irq_o      out  1      DONE & DONE_IE
// BEHAVIOUR
//  Config registers:
//  - 0 CTRL: [0] EN; [1] LOOP; [2] CLEAR (self-clearing, sets count=0); [3] DONE_IE.
//  - 1 STATUS (read-only): [0] BUSY; [1] FULL; [2] EMPTY; [3] DONE; [4] OVF; [15:8] count.
//    DONE and OVF are sticky and cleared by writing 1 to the same bits at index 5.
//  - 2 CMD_DATA: staging data word.
//  - 3 CMD_PUSH: write {dat_i[DLY_W+1:2]=delay, dat_i[1:0]=op} appends {op, CMD_DATA, delay} at index count.
//    Push while count==DEPTH or BUSY is dropped and sets OVF.
//  - 5 W1C: clears DONE/OVF as above.
//  - op 0/1/2/3 maps to GPIO index 1 (OUT) / 3 (SET) / 4 (CLR) / 5 (TGL).
//  Arbitration:
//  - m_* = cpu_* whenever cpu_stb_i=1, same cycle, combinational.
//  - Otherwise m_* carries the sequencer strobe: m_we_o=1, m_byte_sel_o=4'hF.
//  - GPIO read data bypasses this block.
//  FSM IDLE/ISSUE/WAIT, pc indexes the program:
//  - IDLE: EN=1 & count>0 -> ISSUE, pc=0. EN=1 & count==0 -> clear EN, set DONE, stay IDLE.
//  - ISSUE: cpu_stb_i=1 -> hold, no strobe. Otherwise assert one-cycle strobe of entry[pc] and load delay.
//    delay==0 -> advance immediately; else -> WAIT.
//  - WAIT: decrement once per tick; at 0, advance.
//  - advance: pc<count-1 -> pc+1, ISSUE. Last entry: LOOP=1 -> pc=0, ISSUE; else clear EN, set DONE, pc=0, IDLE.
//  Timing and boundaries:
//  - Latency: EN written at edge k -> ISSUE from edge k+1 -> first m_stb_o in cycle k+1..k+2.
//  - Strobe spacing = delay+1 ticks, counted from the actual (possibly CPU-delayed) issue.
//  - EN cleared by software while running: return to IDLE next edge, pc=0, no strobe from a pending ISSUE, DONE not set.
//  - CLEAR while BUSY is ignored.
//  - busy_o = (state!=IDLE).
//  - Reset: all state zero, state=IDLE, program contents undefined.
//    m_stb_o=0, busy_o=0, done_irq_o=0, dat_o=0 for adr 0.
// CONFIGURATION
//  - GPIO_SEQ_PRESCALE_EN defined: register 4 PRESC[15:0] (reset 0); one tick = PRESC+1 clock cycles.
//    The prescaler restarts on each issue.
//  - Undefined: tick = 1 cycle; register 4 reads 0, writes ignored.
// TESTING
//  - Push {op1,0x1,dly2},{op2,0x1,dly0}; EN=1 -> SET 0x1 strobe adr 3; CLR 0x1 strobe adr 4 exactly 3 cycles later.
//    Then DONE=1, EN=0, busy_o=0.
//  - LOOP=1, single TGL entry, delay 4 -> adr 5 strobes every 5 cycles until EN written 0.
//    No strobe after the stop write.
//  - cpu_stb_i held 3 cycles during ISSUE -> m_* mirrors CPU those cycles; sequencer strobe appears on cycle 4.
//  - Push DEPTH+1 entries -> FULL=1, OVF=1, count=DEPTH. Push while BUSY -> OVF, count unchanged.
//  - EN with count 0 -> DONE=1 next cycle, no strobe; done_irq_o=1 iff DONE_IE; W1C DONE -> 0.
//  - rst_i mid-WAIT -> m_stb_o=0, busy_o=0, STATUS=EMPTY next cycle.
//    With GPIO_SEQ_PRESCALE_EN, PRESC=3, delay=1 -> strobe spacing 8 cycles.

Source files
------------

// File: rtl/gpio_seq.sv
// gpio_seq: timed GPIO write-pattern sequencer with CPU-priority port arbiter.
// Software stages a short program of {op, data, delay} entries through the
// config port; the FSM replays it onto the GPIO register port, once or looped.
// Optional feature macro: GPIO_SEQ_PRESCALE_EN adds a tick prescaler (reg 4).
module gpio_seq #(
  parameter int DEPTH = 16,
  parameter int DLY_W = 16,
  parameter int XLEN  = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stb_i,
  input  logic [2:0]      adr_i,
  input  logic            we_i,
  input  logic [XLEN-1:0] dat_i,
  output logic [XLEN-1:0] dat_o,
  input  logic            cpu_stb_i,
  input  logic [3:0]      cpu_adr_i,
  input  logic [3:0]      cpu_byte_sel_i,
  input  logic            cpu_we_i,
  input  logic [XLEN-1:0] cpu_dat_i,
  output logic            m_stb_o,
  output logic [3:0]      m_adr_o,
  output logic [3:0]      m_byte_sel_o,
  output logic            m_we_o,
  output logic [XLEN-1:0] m_dat_o,
  output logic            busy_o,
  output logic            done_irq_o
);
  localparam int PC_W  = $clog2(DEPTH);
  localparam int CNT_W = PC_W + 1;
  localparam int ENT_W = 2 + XLEN + DLY_W;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t             state_reg, state_next;
  logic [PC_W-1:0]    pc_reg, pc_next;
  logic [DLY_W-1:0]   dly_cnt_reg, dly_cnt_next;
  logic [15:0]        presc_cnt_reg, presc_cnt_next;
  logic [15:0]        presc_val;

  logic               en_reg, loop_reg, done_ie_reg, done_reg, ovf_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [XLEN-1:0]    cmd_data_reg;

  logic [ENT_W-1:0]   prog_mem [DEPTH];
  logic [ENT_W-1:0]   entry_reg;
  logic [1:0]         entry_op;
  logic [XLEN-1:0]    entry_dat;
  logic [DLY_W-1:0]   entry_dly;
  logic [3:0]         entry_adr;

  logic cfg_wr, wr_ctrl, wr_data, wr_push, wr_w1c;
  logic busy, full, empty, push_ok, pc_last;
  logic seq_stb, advance, fsm_done;

  assign cfg_wr  = stb_i & we_i;
  assign wr_ctrl = cfg_wr && (adr_i == 3'd0);
  assign wr_data = cfg_wr && (adr_i == 3'd2);
  assign wr_push = cfg_wr && (adr_i == 3'd3);
  assign wr_w1c  = cfg_wr && (adr_i == 3'd5);

  assign busy    = (state_reg != S_IDLE);
  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign push_ok = wr_push & ~full & ~busy;
  assign pc_last = ({1'b0, pc_reg} + CNT_W'(1)) >= count_reg;

  assign entry_op  = entry_reg[ENT_W-1 -: 2];
  assign entry_dat = entry_reg[DLY_W +: XLEN];
  assign entry_dly = entry_reg[DLY_W-1:0];

`ifdef GPIO_SEQ_PRESCALE_EN
  logic [15:0] presc_reg;
  logic        wr_presc;
  assign wr_presc = cfg_wr && (adr_i == 3'd4);
  // Prescaler reload value, software programmable.
  always_ff @(posedge clk_i) begin
    if (rst_i) presc_reg <= '0;
    else if (wr_presc) presc_reg <= dat_i[15:0];
  end
  assign presc_val = presc_reg;
`else
  assign presc_val = '0;
`endif

  // Program store; read is addressed by the next pc so entry_reg always
  // holds the entry the FSM will issue in the coming cycle.
  always_ff @(posedge clk_i) begin
    if (push_ok)
      prog_mem[count_reg[PC_W-1:0]] <= {dat_i[1:0], cmd_data_reg, dat_i[DLY_W+1:2]};
    entry_reg <= prog_mem[pc_next];
  end

  // Operation code to GPIO register index.
  always_comb begin
    entry_adr = 4'd1;
    case (entry_op)
      2'd0: entry_adr = 4'd1;
      2'd1: entry_adr = 4'd3;
      2'd2: entry_adr = 4'd4;
      2'd3: entry_adr = 4'd5;
      default: entry_adr = 4'd1;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= S_IDLE;
      pc_reg        <= '0;
      dly_cnt_reg   <= '0;
      presc_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      dly_cnt_reg   <= dly_cnt_next;
      presc_cnt_reg <= presc_cnt_next;
    end
  end

  // Next-state logic. The issue cycle counts as the first cycle of the
  // first tick, so a delay of d spans (d+1) full ticks between strobes.
  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    dly_cnt_next   = dly_cnt_reg;
    presc_cnt_next = presc_cnt_reg;
    seq_stb        = 1'b0;
    advance        = 1'b0;
    fsm_done       = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (en_reg) begin
          if (!empty) begin
            state_next = S_ISSUE;
            pc_next    = '0;
          end else begin
            fsm_done = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (!en_reg) begin
          state_next = S_IDLE;
          pc_next    = '0;
        end else if (!cpu_stb_i) begin
          seq_stb = 1'b1;
          if (entry_dly == '0) begin
            advance = 1'b1;
          end else begin
            state_next = S_WAIT;
            if (presc_val == '0) begin
              dly_cnt_next   = entry_dly - DLY_W'(1);
              presc_cnt_next = '0;
            end else begin
              dly_cnt_next   = entry_dly;
              presc_cnt_next = presc_val - 16'd1;
            end
          end
        end
      end
      S_WAIT: begin
        if (!en_reg) begin
          state_next = S_IDLE;
          pc_next    = '0;
        end else if (presc_cnt_reg != '0) begin
          presc_cnt_next = presc_cnt_reg - 16'd1;
        end else begin
          presc_cnt_next = presc_val;
          if (dly_cnt_reg == '0) advance = 1'b1;
          else dly_cnt_next = dly_cnt_reg - DLY_W'(1);
        end
      end
      default: begin
        state_next = S_IDLE;
        pc_next    = '0;
      end
    endcase
    if (advance) begin
      if (!pc_last) begin
        pc_next    = pc_reg + PC_W'(1);
        state_next = S_ISSUE;
      end else if (loop_reg) begin
        pc_next    = '0;
        state_next = S_ISSUE;
      end else begin
        pc_next    = '0;
        state_next = S_IDLE;
        fsm_done   = 1'b1;
      end
    end
  end

  // Control/status registers and program count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      en_reg       <= 1'b0;
      loop_reg     <= 1'b0;
      done_ie_reg  <= 1'b0;
      done_reg     <= 1'b0;
      ovf_reg      <= 1'b0;
      count_reg    <= '0;
      cmd_data_reg <= '0;
    end else begin
      if (wr_ctrl) begin
        en_reg      <= dat_i[0];
        loop_reg    <= dat_i[1];
        done_ie_reg <= dat_i[3];
      end else if (fsm_done) begin
        en_reg <= 1'b0;
      end
      if (wr_ctrl && dat_i[2] && !busy) count_reg <= '0;
      else if (push_ok) count_reg <= count_reg + CNT_W'(1);
      if (wr_data) cmd_data_reg <= dat_i;
      if (fsm_done) done_reg <= 1'b1;
      else if (wr_w1c && dat_i[3]) done_reg <= 1'b0;
      if (wr_push && (full || busy)) ovf_reg <= 1'b1;
      else if (wr_w1c && dat_i[4]) ovf_reg <= 1'b0;
    end
  end

  // Config read mux.
  always_comb begin
    dat_o = '0;
    case (adr_i)
      3'd0: dat_o[3:0] = {done_ie_reg, 1'b0, loop_reg, en_reg};
      3'd1: begin
        dat_o[4:0]  = {ovf_reg, done_reg, empty, full, busy};
        dat_o[15:8] = 8'(count_reg);
      end
      3'd2: dat_o = cmd_data_reg;
      3'd4: dat_o[15:0] = presc_val;
      default: dat_o = '0;
    endcase
  end

  // CPU always owns the port while it strobes.
  always_comb begin
    if (cpu_stb_i) begin
      m_stb_o      = 1'b1;
      m_adr_o      = cpu_adr_i;
      m_byte_sel_o = cpu_byte_sel_i;
      m_we_o       = cpu_we_i;
      m_dat_o      = cpu_dat_i;
    end else begin
      m_stb_o      = seq_stb;
      m_adr_o      = entry_adr;
      m_byte_sel_o = 4'hF;
      m_we_o       = 1'b1;
      m_dat_o      = entry_dat;
    end
  end

  assign busy_o     = busy;
  assign done_irq_o = done_reg & done_ie_reg;

endmodule
